// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit: condition codes,
// flag register bit positions and FSM state encodings.
package branch_cond_unit_pkg;

    // Condition codes (CR16 set)
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flag register bit indices
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Request/response FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator: decides whether a 4-bit condition
// holds for a given 5-bit flag word. Shared with conditional-move/Scond logic.
module branch_cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [4:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic taken_s;

    // Decode the condition code against the flag bits
    always_comb begin
        taken_s = 1'b0;
        case (cond)
            COND_EQ: taken_s = flags[FLAG_Z];
            COND_NE: taken_s = ~flags[FLAG_Z];
            COND_CS: taken_s = flags[FLAG_C];
            COND_CC: taken_s = ~flags[FLAG_C];
            COND_HI: taken_s = flags[FLAG_L];
            COND_LS: taken_s = ~flags[FLAG_L];
            COND_GT: taken_s = flags[FLAG_N];
            COND_LE: taken_s = ~flags[FLAG_N];
            COND_FS: taken_s = flags[FLAG_F];
            COND_FC: taken_s = ~flags[FLAG_F];
            COND_LO: taken_s = ~flags[FLAG_L] & ~flags[FLAG_Z];
            COND_HS: taken_s = flags[FLAG_L] | flags[FLAG_Z];
            COND_LT: taken_s = ~flags[FLAG_N] & ~flags[FLAG_Z];
            COND_GE: taken_s = flags[FLAG_N] | flags[FLAG_Z];
            COND_UC: taken_s = 1'b1;
            COND_NV: taken_s = 1'b0;
            default: taken_s = 1'b0;
        endcase
    end

    assign taken = taken_s;

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: accepts a branch request, waits out a same-cycle
// flag write if needed, resolves the condition against the flag register
// and holds the taken/not-taken decision and next PC until accepted.
// Also keeps a saturating count of accepted taken decisions for debug.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        flags,
    input  logic              flag_wr_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cond,
    input  logic [ADDR_W-1:0] req_target,
    input  logic [ADDR_W-1:0] req_pc_plus1,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_taken,
    output logic [ADDR_W-1:0] resp_pc,
    output logic [CNT_W-1:0]  taken_count,
    input  logic              clr_count
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [3:0]          cond_r;
    logic [ADDR_W-1:0]   target_r;
    logic [ADDR_W-1:0]   pc_plus1_r;
    logic                resp_taken_r;
    logic [ADDR_W-1:0]   resp_pc_r;
    logic [CNT_W-1:0]    count_r;

    logic                in_idle_s;
    logic                in_hold_s;
    logic                in_resp_s;
    logic                accept_s;
    logic                eval_now_s;
    logic [3:0]          cond_sel_s;
    logic [ADDR_W-1:0]   target_sel_s;
    logic [ADDR_W-1:0]   pc_plus1_sel_s;
    logic                taken_s;
    logic                count_inc_s;
    logic                count_sat_s;

    assign in_idle_s  = (state_r == IDLE);
    assign in_hold_s  = (state_r == HOLD);
    assign in_resp_s  = (state_r == RESP);
    assign accept_s   = in_idle_s & req_valid;
    // Evaluate immediately unless the flags are being rewritten this edge;
    // in that case the captured request is evaluated one edge later.
    assign eval_now_s = (accept_s & ~flag_wr_en) | in_hold_s;

    // In HOLD the request lives in the capture registers; otherwise use the live request
    assign cond_sel_s     = in_hold_s ? cond_r     : req_cond;
    assign target_sel_s   = in_hold_s ? target_r   : req_target;
    assign pc_plus1_sel_s = in_hold_s ? pc_plus1_r : req_pc_plus1;

    branch_cond_eval u_eval (
        .flags (flags),
        .cond  (cond_sel_s),
        .taken (taken_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = flag_wr_en ? HOLD : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: state_nxt_s = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Capture the request fields on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_r     <= 4'b0000;
            target_r   <= {ADDR_W{1'b0}};
            pc_plus1_r <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            cond_r     <= req_cond;
            target_r   <= req_target;
            pc_plus1_r <= req_pc_plus1;
        end
    end

    // Register the decision and selected next PC when evaluating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_taken_r <= 1'b0;
            resp_pc_r    <= {ADDR_W{1'b0}};
        end else if (eval_now_s) begin
            resp_taken_r <= taken_s;
            resp_pc_r    <= taken_s ? target_sel_s : pc_plus1_sel_s;
        end
    end

    assign count_inc_s = in_resp_s & resp_ready & resp_taken_r;
    assign count_sat_s = (count_r == {CNT_W{1'b1}});

    // Saturating taken-branch counter; clear has priority over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr_count) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_inc_s && !count_sat_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign req_ready   = in_idle_s;
    assign resp_valid  = in_resp_s;
    assign resp_taken  = resp_taken_r;
    assign resp_pc     = resp_pc_r;
    assign taken_count = count_r;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed scenarios plus a full
// condition/flag sweep and random branches against a transaction-level model.
module tb_branch_cond_unit;

    localparam int ADDR_W  = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic [4:0]        flags;
    logic              flag_wr_en;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_cond;
    logic [ADDR_W-1:0] req_target;
    logic [ADDR_W-1:0] req_pc_plus1;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_taken;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  taken_count;
    logic              clr_count;

    int vectors;
    int miscompares;
    int exp_count;

    branch_cond_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flags        (flags),
        .flag_wr_en   (flag_wr_en),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cond     (req_cond),
        .req_target   (req_target),
        .req_pc_plus1 (req_pc_plus1),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_taken   (resp_taken),
        .resp_pc      (resp_pc),
        .taken_count  (taken_count),
        .clr_count    (clr_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety bound on total run time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Compare and count
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: truth of every condition code for one flag word, indexed by code
    function automatic logic ref_taken(input logic [4:0] f, input logic [3:0] c);
        logic n, z, ff, l, cy;
        logic [15:0] truth;
        n = f[4]; z = f[3]; ff = f[2]; l = f[1]; cy = f[0];
        truth = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~ff, ff,
                 ~n, n, ~l, l, ~cy, cy, ~z, z};
        return truth[c];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete branch transaction: accept, optional hazard cycle,
    // 'stall' cycles of backpressure (req_valid held high), then handshake.
    task automatic branch(input logic [3:0] c, input logic [15:0] tgt, input logic [15:0] pc1,
                          input logic [4:0] f0, input logic haz, input logic [4:0] f1,
                          input int stall, input logic clr);
        logic [4:0]  fe;
        logic        et;
        logic [15:0] ep;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        check("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        flags = f0; flag_wr_en = haz; req_valid = 1'b1;
        req_cond = c; req_target = tgt; req_pc_plus1 = pc1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0; flag_wr_en = 1'b0;
        req_cond = 4'($urandom); req_target = 16'($urandom); req_pc_plus1 = 16'($urandom);
        if (haz) begin
            flags = f1;
            flag_wr_en = 1'($urandom);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            check("hold_resp_valid", {31'd0, resp_valid}, 32'd0);
            tick();
            flag_wr_en = 1'b0;
            fe = f1;
        end else begin
            fe = f0;
        end
        flags = 5'($urandom);
        et = ref_taken(fe, c);
        ep = et ? tgt : pc1;
        for (int k = 0; k < stall; k++) begin
            req_valid = 1'b1;
            check("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_resp_taken", {31'd0, resp_taken}, {31'd0, et});
            check("stall_resp_pc", {16'd0, resp_pc}, {16'd0, ep});
            tick();
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("resp_taken", {31'd0, resp_taken}, {31'd0, et});
        check("resp_pc", {16'd0, resp_pc}, {16'd0, ep});
        req_valid = 1'b0; resp_ready = 1'b1; clr_count = clr;
        tick();
        resp_ready = 1'b0; clr_count = 1'b0;
        if (clr) exp_count = 0;
        else if (et && exp_count < CNT_MAX) exp_count++;
        check("taken_count", {28'd0, taken_count}, exp_count);
        check("after_req_ready", {31'd0, req_ready}, 32'd1);
        check("after_resp_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; exp_count = 0;
        reset = 1'b0; flags = 5'd0; flag_wr_en = 1'b0; req_valid = 1'b0;
        req_cond = 4'd0; req_target = 16'd0; req_pc_plus1 = 16'd0;
        resp_ready = 1'b0; clr_count = 1'b0;
        tick(); tick();
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_taken", {31'd0, resp_taken}, 32'd0);
        check("rst_resp_pc", {16'd0, resp_pc}, 32'd0);
        check("rst_taken_count", {28'd0, taken_count}, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Directed: EQ taken with Z set, 1-cycle latency
        branch(4'b0000, 16'h0040, 16'h0011, 5'b01000, 1'b0, 5'b00000, 0, 1'b0);
        // Hazard: HI resolved with the flags written during HOLD
        branch(4'b0100, 16'h1234, 16'h0101, 5'b00000, 1'b1, 5'b00010, 0, 1'b0);
        // Backpressure: 5 stalled cycles with req_valid held high
        branch(4'b1110, 16'hbeef, 16'h0202, 5'b00000, 1'b0, 5'b00000, 5, 1'b0);

        // Reset in RESP while stalled: nothing survives
        flags = 5'b01000; req_valid = 1'b1; req_cond = 4'b1110;
        req_target = 16'h5555; req_pc_plus1 = 16'h6666;
        tick();
        req_valid = 1'b0;
        check("pre_reset_valid", {31'd0, resp_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_count", {28'd0, taken_count}, 32'd0);
        exp_count = 0;
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_resp_pc", {16'd0, resp_pc}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_stale_resp", {31'd0, resp_valid}, 32'd0);
        end

        // Sweep all codes over all flag patterns, hazard path on odd patterns
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                branch(4'(c), 16'($urandom), 16'($urandom), 5'(f), 1'(f & 1),
                       5'(f), 0, 1'b0);
            end
        end

        // Counter saturation then clear-with-taken-handshake priority
        for (int k = 0; k < CNT_MAX + 3; k++) begin
            branch(4'b1110, 16'($urandom), 16'($urandom), 5'($urandom), 1'b0, 5'd0, 0, 1'b0);
        end
        check("count_saturated", {28'd0, taken_count}, CNT_MAX);
        branch(4'b1110, 16'h0aaa, 16'h0bbb, 5'd0, 1'b0, 5'd0, 0, 1'b1);
        check("count_cleared", {28'd0, taken_count}, 32'd0);

        // Random branches with random hazards and stalls
        for (int k = 0; k < 200; k++) begin
            branch(4'($urandom), 16'($urandom), 16'($urandom), 5'($urandom),
                   1'($urandom), 5'($urandom), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
